// File: rtl/board_io_pkg.sv
// Shared types and helpers for the board I/O conditioning block.
package board_io_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_PWM   = 2'b11
  } led_mode_t;

  typedef enum logic [1:0] {
    PHY_ASSERT = 2'd0,
    PHY_WAIT   = 2'd1,
    PHY_READY  = 2'd2
  } phy_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/board_io_ctrl_if.sv
// Pin-side bundle between the board top-level and board_io_ctrl.
interface board_io_ctrl_if #(
  parameter int N_SW     = 4,
  parameter int N_LED    = 4,
  parameter int PWM_BITS = 8
) ();
  logic [N_SW-1:0]           sw_raw;
  logic [N_SW-1:0]           sw_db;
  logic [N_SW-1:0]           sw_rise;
  logic [N_SW-1:0]           sw_fall;
  logic [2*N_LED-1:0]        led_mode;
  logic [PWM_BITS*N_LED-1:0] led_duty;
  logic [N_LED-1:0]          led_out;
  logic                      phy_rst_req;
  logic                      phy_resetn;
  logic                      phy_ready;

  modport master (
    output sw_raw, led_mode, led_duty, phy_rst_req,
    input  sw_db, sw_rise, sw_fall, led_out, phy_resetn, phy_ready
  );

  modport slave (
    input  sw_raw, led_mode, led_duty, phy_rst_req,
    output sw_db, sw_rise, sw_fall, led_out, phy_resetn, phy_ready
  );
endinterface

// File: rtl/io_debounce.sv
// One switch channel: 2-flop synchroniser, stability counter, level and edge pulses.
module io_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = cnt_w(DEBOUNCE_CYC);

  logic          r_meta, r_s, r_db, r_rise, r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_s    <= 1'b0;
      r_db   <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_s    <= r_meta;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (r_s == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // Accept the new level and flag the edge on the same clock.
        r_db   <= r_s;
        r_cnt  <= '0;
        r_rise <= r_s;
        r_fall <= ~r_s;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O conditioning: debounced switches, LED off/on/blink/PWM drive,
// and Ethernet PHY reset sequencing.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int N_SW         = 4,
  parameter int N_LED        = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BLINK_CYC    = 12500000,
  parameter int PWM_BITS     = 8,
  parameter int PHY_RST_CYC  = 500000,
  parameter int PHY_WAIT_CYC = 250000
) (
  input  logic            clk,
  input  logic            resetn,
  board_io_ctrl_if.slave  bus
);
  localparam int BW   = cnt_w(BLINK_CYC);
  localparam int PMAX = (PHY_RST_CYC > PHY_WAIT_CYC) ? PHY_RST_CYC : PHY_WAIT_CYC;
  localparam int PW   = cnt_w(PMAX);

  // ---------------- switches ----------------
  logic [N_SW-1:0] w_sw_db, w_sw_rise, w_sw_fall;

  generate
    for (genvar g = 0; g < N_SW; g++) begin : g_sw
      io_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk    (clk),
        .resetn (resetn),
        .i_raw  (bus.sw_raw[g]),
        .o_db   (w_sw_db[g]),
        .o_rise (w_sw_rise[g]),
        .o_fall (w_sw_fall[g])
      );
    end
  endgenerate

  assign bus.sw_db   = w_sw_db;
  assign bus.sw_rise = w_sw_rise;
  assign bus.sw_fall = w_sw_fall;

  // ---------------- LEDs ----------------
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [BW-1:0]       r_presc;
  logic                r_blink_ph;
  logic [N_LED-1:0]    r_led, w_led_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pwm_cnt  <= '0;
      r_presc    <= '0;
      r_blink_ph <= 1'b0;
      r_led      <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (r_presc == BW'(BLINK_CYC - 1)) begin
        r_presc    <= '0;
        r_blink_ph <= ~r_blink_ph;
      end else begin
        r_presc <= r_presc + BW'(1);
      end
      r_led <= w_led_nxt;
    end
  end

  always_comb begin
    w_led_nxt = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (led_mode_t'(bus.led_mode[2*i +: 2]))
        LED_OFF:   w_led_nxt[i] = 1'b0;
        LED_ON:    w_led_nxt[i] = 1'b1;
        LED_BLINK: w_led_nxt[i] = r_blink_ph;
        LED_PWM:   w_led_nxt[i] = (r_pwm_cnt < bus.led_duty[PWM_BITS*i +: PWM_BITS]);
        default:   w_led_nxt[i] = 1'b0;
      endcase
    end
  end

  assign bus.led_out = r_led;

  // ---------------- PHY reset sequencer ----------------
  phy_state_t    r_state, w_state_nxt;
  logic [PW-1:0] r_pcnt, w_pcnt_nxt;
  logic          r_phy_resetn, r_phy_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= PHY_ASSERT;
      r_pcnt       <= '0;
      r_phy_resetn <= 1'b0;
      r_phy_ready  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pcnt       <= w_pcnt_nxt;
      // Pins come straight from flops so the PHY never sees decode glitches.
      r_phy_resetn <= (w_state_nxt != PHY_ASSERT);
      r_phy_ready  <= (w_state_nxt == PHY_READY);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt + PW'(1);
    if (bus.phy_rst_req) begin
      w_state_nxt = PHY_ASSERT;
      w_pcnt_nxt  = '0;
    end else begin
      case (r_state)
        PHY_ASSERT: if (r_pcnt == PW'(PHY_RST_CYC - 1)) begin
          w_state_nxt = PHY_WAIT;
          w_pcnt_nxt  = '0;
        end
        PHY_WAIT: if (r_pcnt == PW'(PHY_WAIT_CYC - 1)) begin
          w_state_nxt = PHY_READY;
          w_pcnt_nxt  = '0;
        end
        PHY_READY: w_pcnt_nxt = r_pcnt;
        default: begin
          w_state_nxt = PHY_ASSERT;
          w_pcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign bus.phy_resetn = r_phy_resetn;
  assign bus.phy_ready  = r_phy_ready;

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board I/O conditioning block sitting between dev-kit pins and the FPGAChip core in a board top-level. It synchronises and debounces N user switches/buttons and produces edge pulses. It drives N user LEDs in off/on/blink/PWM modes. It also sequences the Ethernet PHY reset (hold-low, then settle, then ready) instead of tying the PHY pins to constants.

## Interface

**Parameters**
- `N_SW`, 4: switch/button channels.
- `N_LED`, 4: LED channels.
- `DEBOUNCE_CYC`, 500000: stable cycles required before a switch change is accepted (10 ms at 50 MHz); ≥2.
- `BLINK_CYC`, 12500000: cycles per blink half-period (250 ms at 50 MHz); ≥1.
- `PWM_BITS`, 8: PWM counter and duty width.
- `PHY_RST_CYC`, 500000: cycles `phy_resetn` is held low; ≥1.
- `PHY_WAIT_CYC`, 250000: cycles after reset release before `phy_ready`; ≥1.

**Ports**
- `clk` in 1: single clock for the block (board 50 MHz).
- `resetn` in 1: asynchronous, active-low reset.
- `sw_raw` in N_SW: raw, asynchronous switch/button pins.
- `sw_db` out N_SW: debounced level.
- `sw_rise` out N_SW: 1-cycle pulse on debounced 0→1.
- `sw_fall` out N_SW: 1-cycle pulse on debounced 1→0.
- `led_mode` in 2*N_LED: per-LED mode. Channel i uses bits [2i+1:2i]: 00 off, 01 on, 10 blink, 11 PWM.
- `led_duty` in PWM_BITS*N_LED: per-LED duty in slice [PWM_BITS*(i+1)-1 : PWM_BITS*i].
- `led_out` out N_LED: LED drive, active high.
- `phy_rst_req` in 1: synchronous pulse requesting a new PHY reset sequence.
- `phy_resetn` out 1: PHY reset, active low.
- `phy_ready` out 1: high once PHY settle time has elapsed.

## Operation

**Switch path (per channel)**
- 2-flop synchroniser producing `s`. The synchroniser resets to 0.
- Counter `cnt`, sized `$clog2(DEBOUNCE_CYC)`:
  - If `s == sw_db`: `cnt` ← 0.
  - Otherwise `cnt` increments.
  - When `cnt == DEBOUNCE_CYC-1` and `s != sw_db`: `sw_db` ← `s`, `cnt` ← 0, and the matching edge pulse is asserted on that same clock edge.
- A glitch shorter than `DEBOUNCE_CYC` cycles restarts the count and produces no change.

**LED path**
- Shared free-running `pwm_cnt`, PWM_BITS wide, wraps at 2^PWM_BITS−1 → 0.
- Shared blink prescaler counting 0..BLINK_CYC−1. On wrap it toggles `blink_ph`.
- Mode 00: `led_out`=0. Mode 01: `led_out`=1. Mode 10: `led_out`=`blink_ph`.
- Mode 11: `led_out` = (`pwm_cnt` < duty). Duty 0 gives constant off; maximum duty gives on for (2^PWM_BITS−1) of 2^PWM_BITS cycles.
- `led_out` is registered. A mode or duty change takes effect on the next edge, with no reset of the shared counters.

**PHY sequencer FSM**
- States:
  - ASSERT: `phy_resetn`=0, `phy_ready`=0.
  - WAIT: `phy_resetn`=1, `phy_ready`=0.
  - READY: `phy_resetn`=1, `phy_ready`=1.
- ASSERT → WAIT after `PHY_RST_CYC` cycles in ASSERT.
- WAIT → READY after `PHY_WAIT_CYC` cycles in WAIT.
- `phy_rst_req`=1 in any state → ASSERT with the counter cleared. This includes mid-ASSERT, which restarts the full hold time.
- A request on the same cycle as a terminal count takes priority over the transition.

## Timing

**Reset values (`resetn`=0)**
- `sw_db`, `sw_rise`, `sw_fall`, `led_out`, `pwm_cnt`, `blink_ph`, prescaler, debounce counters: all 0.
- FSM in ASSERT with counter 0, so `phy_resetn`=0 and `phy_ready`=0.

**Latencies**
- Switch: `sw_raw` stable change → `sw_db` and edge pulse after 2 (sync) + `DEBOUNCE_CYC` cycles.
- LED: mode/duty → `led_out` is 1 cycle.
- PHY, after reset release or after the cycle carrying `phy_rst_req`:
  - `phy_resetn` rises exactly `PHY_RST_CYC` cycles later.
  - `phy_ready` rises `PHY_WAIT_CYC` cycles after that.

**Reset mid-operation**
- Asynchronous reset returns all state to the reset values immediately, with no pulses emitted.
- Deassertion is assumed synchronised upstream.

## Structure

**Package `board_io_pkg`**
- `led_mode_t` enum: `LED_OFF`, `LED_ON`, `LED_BLINK`, `LED_PWM`.
- `phy_state_t` enum: `PHY_ASSERT`, `PHY_WAIT`, `PHY_READY`.

**Sub-module `io_debounce`**
- One channel: synchroniser, counter, level, and rise/fall pulses.
- Parameter `DEBOUNCE_CYC`.
- Instantiated `N_SW` times in a generate loop.

LED logic and the PHY FSM stay in `board_io_ctrl`.

## Test plan

Bench parameters: `DEBOUNCE_CYC`=4, `BLINK_CYC`=3, `PWM_BITS`=4, `PHY_RST_CYC`=5, `PHY_WAIT_CYC`=3.

1. Reset release:
   - `phy_resetn`=0 for 5 cycles, then 1.
   - `phy_ready`=1 exactly 3 cycles later.
   - All LEDs 0 and `sw_db`=0 throughout.
2. `sw_raw[2]` 0→1 held:
   - `sw_db[2]`=1 and a single `sw_rise[2]` pulse 6 cycles after the change.
   - 3-cycle glitch on `sw_raw[1]`: no change on `sw_db[1]` and no pulses.
3. LED0 mode 11:
   - duty 5: high 5 of every 16 cycles.
   - duty 0: always 0.
   - duty 15: high 15 of 16.
   - LED1 mode 10: toggles every 3 cycles.
4. `phy_rst_req` pulsed in READY:
   - `phy_ready` and `phy_resetn` both fall 1 cycle later.
   - Full 5+3 sequence replays.
   - A second pulse 2 cycles into ASSERT restarts the 5-cycle hold.
5. Asynchronous reset asserted mid-WAIT and mid-debounce:
   - All outputs return to reset values without waiting for a clock edge.
   - No `sw_rise`/`sw_fall` pulses after release.
